// File: rtl/stream_rr_arbiter.sv
// Purpose : round-robin share of one registered valid/ready output among N sources,
//           each grant held for at most BEATS beats before re-arbitration.
// Latency : one cycle from upstream accept to oValid_BM/oData_BM; one idle
//           arbitration cycle between grants.
// Backpressure: iReady_BM low with a beat held stalls the granted source
//           (oReady_AM all zero) without ending its grant; nothing is dropped.
//
// Ports:
//   iCLK, iRST           clock (posedge) and async active-high reset
//   iValid_AM/oReady_AM  per-requester handshake; at most one ready bit high
//   iData_AM             requester k data at [k*WIDTH +: WIDTH]
//   oValid_BM/iReady_BM  downstream handshake, valid and data registered
//   oData_BM             downstream data
//   oGrant               current/last granted requester (round-robin pointer)
//   oBusy                high while a grant is active
module stream_rr_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int BEATS = 4
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [N-1:0]         iValid_AM,
    output logic [N-1:0]         oReady_AM,
    input  logic [N*WIDTH-1:0]   iData_AM,
    output logic                 oValid_BM,
    input  logic                 iReady_BM,
    output logic [WIDTH-1:0]     oData_BM,
    output logic [$clog2(N)-1:0] oGrant,
    output logic                 oBusy
);

    localparam int GW = $clog2(N);
    localparam int CW = $clog2(BEATS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] beatCnt;
    logic          outFree;
    logic          accept;
    logic          lastBeat;
    logic          pickVld;
    logic [GW-1:0] pickIdx;

    // The output register can take a new beat when empty or being drained.
    assign outFree  = !oValid_BM || iReady_BM;
    assign oBusy    = (state == GRANT);
    assign accept   = iValid_AM[oGrant] && oReady_AM[oGrant];
    assign lastBeat = (beatCnt == CW'(BEATS - 1));

    // Ready depends only on registered state and iReady_BM, never on iValid_AM.
    always_comb begin
        oReady_AM = '0;
        if ((state == GRANT) && outFree) begin
            oReady_AM[oGrant] = 1'b1;
        end
    end

    // Round-robin search: first valid strictly above the pointer, otherwise
    // the lowest valid overall (wrap). The pointer itself is checked last.
    always_comb begin
        pickVld = 1'b0;
        pickIdx = oGrant;
        for (int k = 0; k < N; k++) begin
            if (!pickVld && iValid_AM[GW'(k)] && (GW'(k) > oGrant)) begin
                pickVld = 1'b1;
                pickIdx = GW'(k);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!pickVld && iValid_AM[GW'(k)]) begin
                pickVld = 1'b1;
                pickIdx = GW'(k);
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state     <= IDLE;
            oValid_BM <= 1'b0;
            oData_BM  <= '0;
            oGrant    <= GW'(N - 1);
            beatCnt   <= '0;
        end else begin
            // Output stage: load on accept, otherwise empty when drained.
            if (accept) begin
                oValid_BM <= 1'b1;
                oData_BM  <= iData_AM[oGrant*WIDTH +: WIDTH];
            end else if (iReady_BM) begin
                oValid_BM <= 1'b0;
            end

            case (state)
                IDLE: begin
                    beatCnt <= '0;
                    if (pickVld) begin
                        oGrant <= pickIdx;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        beatCnt <= beatCnt + 1'b1;
                        if (lastBeat) begin
                            state <= IDLE;
                        end
                    end else if (outFree && !iValid_AM[oGrant]) begin
                        // Granted source went idle while it could have sent.
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
module tb_stream_rr_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int BEATS = 4;
    localparam int GW    = $clog2(N);
    localparam int NOLIM = 1 << 30;

    logic               iCLK;
    logic               iRST;
    logic [N-1:0]       iValid_AM;
    logic [N-1:0]       oReady_AM;
    logic [N*WIDTH-1:0] iData_AM;
    logic               oValid_BM;
    logic               iReady_BM;
    logic [WIDTH-1:0]   oData_BM;
    logic [GW-1:0]      oGrant;
    logic               oBusy;

    stream_rr_arbiter #(.N(N), .WIDTH(WIDTH), .BEATS(BEATS)) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iValid_AM (iValid_AM),
        .oReady_AM (oReady_AM),
        .iData_AM  (iData_AM),
        .oValid_BM (oValid_BM),
        .iReady_BM (iReady_BM),
        .oData_BM  (oData_BM),
        .oGrant    (oGrant),
        .oBusy     (oBusy)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int checkCnt;
    int failCnt;
    int cyc;
    int run;
    int srcBase[N];
    int srcCnt[N];
    int srcLim[N];
    int accCnt[N];
    int expN[N];
    logic [WIDTH-1:0] outQ[$];
    int               outCyc[$];
    logic [GW-1:0]    outGnt[$];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            iData_AM[k*WIDTH +: WIDTH] = 8'(srcBase[k] + (srcCnt[k] % 64));
        end
    endtask

    // One clock: observe handshakes at negedge, advance sources after posedge.
    task automatic cycle();
        logic [N-1:0] pop;
        @(negedge iCLK);
        pop = iValid_AM & oReady_AM;
        if (!oBusy) run = 0;
        if (pop != '0) begin
            run++;
            checkVal("grant_run_le_beats", 32'(run <= BEATS), 32'd1);
        end
        if (oValid_BM && iReady_BM) begin
            outQ.push_back(oData_BM);
            outCyc.push_back(cyc);
            outGnt.push_back(oGrant);
        end
        @(posedge iCLK);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (pop[k]) begin
                srcCnt[k]++;
                accCnt[k]++;
                if (srcCnt[k] >= srcLim[k]) iValid_AM[k] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic resetDut();
        iRST      = 1'b1;
        iReady_BM = 1'b1;
        iValid_AM = '0;
        for (int k = 0; k < N; k++) begin
            srcBase[k] = k * 64;
            srcCnt[k]  = 0;
            srcLim[k]  = NOLIM;
            accCnt[k]  = 0;
        end
        drive();
        repeat (2) @(negedge iCLK);
        iRST = 1'b0;
        @(posedge iCLK);
        #1;
        outQ.delete();
        outCyc.delete();
        outGnt.delete();
        run = 0;
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic [1:0]       p;
        checkCnt  = 0;
        failCnt   = 0;
        cyc       = 0;
        run       = 0;
        iRST      = 1'b0;
        iReady_BM = 1'b0;
        iValid_AM = '0;
        iData_AM  = '0;

        // Reset state
        #1 iRST = 1'b1;
        #1;
        checkVal("rst_valid", 32'(oValid_BM), 32'd0);
        checkVal("rst_data",  32'(oData_BM),  32'd0);
        checkVal("rst_ready", 32'(oReady_AM), 32'd0);
        checkVal("rst_grant", 32'(oGrant),    32'd3);
        checkVal("rst_busy",  32'(oBusy),     32'd0);

        // Single source on port 2, 8 beats
        resetDut();
        srcBase[2] = 8'h10;
        srcLim[2]  = 8;
        iValid_AM[2] = 1'b1;
        drive();
        for (int i = 0; i < 40 && outQ.size() < 8; i++) cycle();
        checkVal("t2_beats", 32'(outQ.size()), 32'd8);
        for (int i = 0; i < outQ.size() && i < 8; i++) begin
            checkVal("t2_data",  32'(outQ[i]),   32'(8'h10 + i));
            checkVal("t2_grant", 32'(outGnt[i]), 32'd2);
        end
        if (outQ.size() >= 8) begin
            checkVal("t2_burst1", 32'(outCyc[3] - outCyc[0]), 32'd3);
            checkVal("t2_gap",    32'(outCyc[4] - outCyc[3]), 32'd2);
            checkVal("t2_burst2", 32'(outCyc[7] - outCyc[4]), 32'd3);
        end

        // Round robin, all ports always valid
        resetDut();
        iValid_AM = '1;
        drive();
        for (int i = 0; i < 80 && outQ.size() < 20; i++) cycle();
        checkVal("t3_beats", 32'(outQ.size()), 32'd20);
        for (int j = 0; j < outQ.size() && j < 20; j++) begin
            checkVal("t3_data", 32'(outQ[j]), 32'(((j / 4) % 4) * 64 + (j / 16) * 4 + (j % 4)));
        end

        // Backpressure on port 0
        resetDut();
        srcBase[0] = 8'hA0;
        srcLim[0]  = 8;
        iValid_AM[0] = 1'b1;
        drive();
        for (int i = 0; i < 10 && !oValid_BM; i++) cycle();
        checkVal("t4_first", 32'(oData_BM), 32'hA0);
        iReady_BM = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checkVal("t4_hold_valid", 32'(oValid_BM), 32'd1);
            checkVal("t4_hold_data",  32'(oData_BM),  32'hA0);
            checkVal("t4_hold_ready", 32'(oReady_AM), 32'd0);
            checkVal("t4_hold_grant", 32'(oGrant),    32'd0);
            checkVal("t4_hold_busy",  32'(oBusy),     32'd1);
        end
        iReady_BM = 1'b1;
        for (int i = 0; i < 40 && outQ.size() < 8; i++) cycle();
        repeat (3) cycle();
        checkVal("t4_beats", 32'(outQ.size()), 32'd8);
        for (int i = 0; i < outQ.size() && i < 8; i++) begin
            checkVal("t4_data", 32'(outQ[i]), 32'(8'hA0 + i));
        end

        // Async reset mid-cycle with a beat held
        srcLim[0] = NOLIM;
        iValid_AM[0] = 1'b1;
        iReady_BM = 1'b0;
        drive();
        for (int i = 0; i < 10 && !oValid_BM; i++) cycle();
        checkVal("t1_pre_valid", 32'(oValid_BM), 32'd1);
        #3 iRST = 1'b1;
        #1;
        checkVal("t1_valid", 32'(oValid_BM), 32'd0);
        checkVal("t1_ready", 32'(oReady_AM), 32'd0);
        checkVal("t1_grant", 32'(oGrant),    32'd3);
        checkVal("t1_busy",  32'(oBusy),     32'd0);
        iValid_AM = '0;
        iReady_BM = 1'b1;
        #2 iRST = 1'b0;
        outQ.delete();
        repeat (4) cycle();
        checkVal("t1_no_beat_after", 32'(outQ.size()), 32'd0);

        // Early release: port 1 sends 2 then drops, port 3 waiting
        resetDut();
        srcBase[1] = 8'h50;
        srcBase[3] = 8'h70;
        srcLim[1]  = 2;
        iValid_AM[1] = 1'b1;
        iValid_AM[3] = 1'b1;
        drive();
        for (int i = 0; i < 80 && outQ.size() < 12; i++) begin
            cycle();
            if (oBusy && (oGrant == 2'd3) && (srcLim[1] == 2)) begin
                srcLim[1] = NOLIM;
                iValid_AM[1] = 1'b1;
            end
        end
        checkVal("t5_beats", 32'(outQ.size()), 32'd12);
        begin
            logic [7:0] exp5 [12] = '{8'h50, 8'h51, 8'h70, 8'h71, 8'h72, 8'h73,
                                      8'h52, 8'h53, 8'h54, 8'h55, 8'h74, 8'h75};
            for (int i = 0; i < outQ.size() && i < 12; i++) begin
                checkVal("t5_data", 32'(outQ[i]), 32'(exp5[i]));
            end
        end

        // Random valids and downstream ready with per-port scoreboard
        resetDut();
        for (int k = 0; k < N; k++) expN[k] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < N; k++) iValid_AM[k] = ($urandom_range(0, 3) != 0);
            iReady_BM = ($urandom_range(0, 3) != 0);
            cycle();
            while (outQ.size() > 0) begin
                d = outQ.pop_front();
                p = d[7:6];
                checkVal("t6_data", 32'(d[5:0]), 32'(expN[p] % 64));
                expN[p]++;
            end
        end
        iValid_AM = '0;
        iReady_BM = 1'b1;
        repeat (5) cycle();
        while (outQ.size() > 0) begin
            d = outQ.pop_front();
            p = d[7:6];
            checkVal("t6_data", 32'(d[5:0]), 32'(expN[p] % 64));
            expN[p]++;
        end
        for (int k = 0; k < N; k++) begin
            checkVal("t6_delivered", 32'(expN[k]), 32'(accCnt[k]));
            checkVal("t6_served", 32'(expN[k] > 100), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
        $finish;
    end

endmodule
